// File: rtl/speed_encoder.sv
// Speed-key encoder: turns debounced up/down/normal keys into a signed speed level
// with hold-to-repeat, normal recall and lock, and emits the 4-bit player speed code.
module speed_encoder #(
  parameter int HOLD_CYC   = 6_000_000,
  parameter int REPEAT_CYC = 2_400_000,
  parameter int MAX_LEVEL  = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_norm,
  input  logic       i_lock,
  output logic [3:0] o_speed,
  output logic       o_fast_or_slow,
  output logic [3:0] o_factor,
  output logic       o_update
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic signed [3:0]  LVL_MAX   = 4'(MAX_LEVEL);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCK} state_t;

  function automatic logic signed [3:0] step_level(input logic signed [3:0] lvl,
                                                   input logic up);
    if (up) return (lvl >= LVL_MAX) ? lvl : lvl + 4'sd1;
    else    return (lvl <= -LVL_MAX) ? lvl : lvl - 4'sd1;
  endfunction

  function automatic logic [2:0] level_mag(input logic signed [3:0] lvl);
    logic signed [3:0] a;
    a = lvl[3] ? -lvl : lvl;
    return a[2:0];
  endfunction

  logic up_p0, dn_p0, nm_p0, lk_p0, arm_p0;
  logic up_p1, dn_p1, nm_p1, arm_p1;
  state_t            state, state_nxt;
  logic signed [3:0] lvl, lvl_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_last;
  logic              dir_up, dir_nxt, key_alone;
  logic              up_press, dn_press, nm_press;

  // p0: sampled keys; p1: previous sample. arm_p1 masks keys already held at reset release.
  assign up_press = arm_p1 & up_p0 & ~up_p1;
  assign dn_press = arm_p1 & dn_p0 & ~dn_p1;
  assign nm_press = arm_p1 & nm_p0 & ~nm_p1;

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    cnt_nxt   = cnt;
    dir_nxt   = dir_up;
    key_alone = dir_up ? (up_p0 & ~dn_p0) : (dn_p0 & ~up_p0);
    cnt_last  = (state == HOLD) ? HOLD_LAST : REP_LAST;
    case (state)
      IDLE: begin
        if (!lk_p0) begin
          if (nm_press) begin
            lvl_nxt = 4'sd0;
          end else if (up_p0 && dn_p0) begin
            state_nxt = BLOCK;
          end else if (up_press || dn_press) begin
            lvl_nxt   = step_level(lvl, up_press);
            dir_nxt   = up_press;
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end
        end
      end
      HOLD, REPEAT: begin
        if (!key_alone || nm_p0 || lk_p0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (nm_press && !lk_p0) lvl_nxt = 4'sd0;
        end else if (cnt == cnt_last) begin
          lvl_nxt   = step_level(lvl, dir_up);
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BLOCK: begin
        if (!up_p0 && !dn_p0 && !nm_p0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      up_p0    <= 1'b0;
      dn_p0    <= 1'b0;
      nm_p0    <= 1'b0;
      lk_p0    <= 1'b0;
      arm_p0   <= 1'b0;
      up_p1    <= 1'b0;
      dn_p1    <= 1'b0;
      nm_p1    <= 1'b0;
      arm_p1   <= 1'b0;
      state    <= IDLE;
      lvl      <= 4'sd0;
      cnt      <= '0;
      dir_up   <= 1'b0;
      o_update <= 1'b0;
    end else begin
      up_p0    <= i_up;
      dn_p0    <= i_down;
      nm_p0    <= i_norm;
      lk_p0    <= i_lock;
      arm_p0   <= 1'b1;
      up_p1    <= up_p0;
      dn_p1    <= dn_p0;
      nm_p1    <= nm_p0;
      arm_p1   <= arm_p0;
      state    <= state_nxt;
      lvl      <= lvl_nxt;
      cnt      <= cnt_nxt;
      dir_up   <= dir_nxt;
      o_update <= (lvl_nxt != lvl);
    end
  end

  // Output encoding from the registered level.
  assign o_fast_or_slow = lvl[3];
  assign o_speed        = {lvl[3], level_mag(lvl)};
  assign o_factor       = {1'b0, level_mag(lvl)} + 4'd1;

endmodule
